// File: rtl/alien_spawn_ctrl.sv
// alien_spawn_ctrl: level sequencer for a fixed pool of alien slots.
// It paces spawns by video frames, tracks which slots hold a live alien,
// counts remaining aliens and reports level completion.
// Optional build macro ALIEN_PLAYER_FREEZE_EN adds a post-player-death freeze
// period (FREEZE state) before spawning resumes. Without it, spawning resumes
// directly after a player death and FREEZE_FRAMES is unused.
module alien_spawn_ctrl #(
  parameter int NUM_SLOTS          = 4,
  parameter int SPAWN_DELAY_FRAMES = 120,
  parameter int TOTAL_ALIENS       = 8,
  parameter int FREEZE_FRAMES      = 90
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 start_level,
  input  logic [NUM_SLOTS-1:0] alien_died,
  input  logic                 player_died,
  output logic [NUM_SLOTS-1:0] slot_alive,
  output logic [NUM_SLOTS-1:0] spawn_pulse,
  output logic [7:0]           aliens_left,
  output logic                 level_clear
);

  localparam int CNT_W = $clog2(SPAWN_DELAY_FRAMES + 1);
  localparam int SPN_W = $clog2(TOTAL_ALIENS + 1);
  localparam int POP_W = $clog2(NUM_SLOTS + 1);

  localparam logic [CNT_W-1:0] DELAY_C     = CNT_W'(SPAWN_DELAY_FRAMES);
  localparam logic [SPN_W-1:0] TOTAL_C     = SPN_W'(TOTAL_ALIENS);
  localparam logic [7:0]       LEFT_INIT_C = 8'(TOTAL_ALIENS);

`ifdef ALIEN_PLAYER_FREEZE_EN
  localparam int FRZ_W = $clog2(FREEZE_FRAMES + 1);
  localparam logic [FRZ_W-1:0] FREEZE_C = FRZ_W'(FREEZE_FRAMES);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SPAWN,
    ST_FREEZE,
    ST_DONE
  } state_t;

  // Isolate the lowest set bit: picks the lowest-index free slot.
  function automatic logic [NUM_SLOTS-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
    return v & (~v + NUM_SLOTS'(1));
  endfunction

  // Number of set bits in a slot mask.
  function automatic logic [POP_W-1:0] popcount(input logic [NUM_SLOTS-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

  // Frame counter step that holds at the spawn delay instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_frame_inc(input logic [CNT_W-1:0] c,
                                                     input logic            tick);
    if (tick && (c != DELAY_C)) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  state_t               state_q,   state_d;
  logic [CNT_W-1:0]     cnt_q,     cnt_d;
  logic [SPN_W-1:0]     spawned_q, spawned_d;
  logic [7:0]           left_q,    left_d;
  logic [NUM_SLOTS-1:0] alive_q,   alive_d;
  logic [NUM_SLOTS-1:0] pulse_q,   pulse_d;
  logic                 clear_q,   clear_d;
`ifdef ALIEN_PLAYER_FREEZE_EN
  logic [FRZ_W-1:0]     frz_q,     frz_d;
`endif

  logic [NUM_SLOTS-1:0] kill_mask;
  logic [NUM_SLOTS-1:0] live_after;
  logic [NUM_SLOTS-1:0] free_mask;
  logic [NUM_SLOTS-1:0] pick_mask;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 spawn_ok;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    spawned_d = spawned_q;
    left_d    = left_q;
    alive_d   = alive_q;
    pulse_d   = '0;
    clear_d   = 1'b0;
`ifdef ALIEN_PLAYER_FREEZE_EN
    frz_d     = frz_q;
`endif

    // Deaths only count against slots that were alive at cycle start; the
    // free mask also uses cycle-start occupancy, so a slot vacated this cycle
    // becomes eligible for spawning one cycle later.
    kill_mask  = alien_died & alive_q;
    live_after = alive_q & ~kill_mask;
    free_mask  = ~alive_q;
    pick_mask  = lowest_set(free_mask);
    cnt_inc    = sat_frame_inc(cnt_q, startOfFrame);
    spawn_ok   = (cnt_inc == DELAY_C) && (spawned_q < TOTAL_C) && (|free_mask);

    if (start_level) begin
      state_d   = ST_WAIT;
      cnt_d     = '0;
      spawned_d = '0;
      left_d    = LEFT_INIT_C;
      alive_d   = '0;
`ifdef ALIEN_PLAYER_FREEZE_EN
      frz_d     = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_DONE: begin
          clear_d = 1'b1;
        end

        ST_WAIT, ST_SPAWN: begin
          alive_d = live_after;
          left_d  = left_q - 8'(popcount(kill_mask));

          if (state_q == ST_SPAWN) begin
            // The pulse issued this cycle commits the slot as alive.
            alive_d   = live_after | pulse_q;
            spawned_d = spawned_q + SPN_W'(1);
            cnt_d     = '0;
            state_d   = ST_WAIT;
          end else begin
            cnt_d = cnt_inc;
            if (spawn_ok) begin
              state_d = ST_SPAWN;
              pulse_d = pick_mask;
            end
          end

          // Player death: aliens still on screen return to the spawn pool,
          // kills from this same cycle have already been accounted above.
          if (player_died) begin
            alive_d   = '0;
            pulse_d   = '0;
            cnt_d     = '0;
            spawned_d = spawned_q - SPN_W'(popcount(live_after));
`ifdef ALIEN_PLAYER_FREEZE_EN
            state_d   = ST_FREEZE;
            frz_d     = '0;
`else
            state_d   = ST_WAIT;
`endif
          end

          if (left_d == 8'd0) begin
            state_d = ST_DONE;
            pulse_d = '0;
            alive_d = '0;
            clear_d = 1'b1;
          end
        end

`ifdef ALIEN_PLAYER_FREEZE_EN
        ST_FREEZE: begin
          if (startOfFrame) begin
            if (frz_q + FRZ_W'(1) == FREEZE_C) begin
              frz_d   = '0;
              cnt_d   = '0;
              state_d = ST_WAIT;
            end else begin
              frz_d = frz_q + FRZ_W'(1);
            end
          end
        end
`endif

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything including a pulse in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      spawned_q <= '0;
      left_q    <= '0;
      alive_q   <= '0;
      pulse_q   <= '0;
      clear_q   <= 1'b0;
`ifdef ALIEN_PLAYER_FREEZE_EN
      frz_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spawned_q <= spawned_d;
      left_q    <= left_d;
      alive_q   <= alive_d;
      pulse_q   <= pulse_d;
      clear_q   <= clear_d;
`ifdef ALIEN_PLAYER_FREEZE_EN
      frz_q     <= frz_d;
`endif
    end
  end

  assign slot_alive  = alive_q;
  assign spawn_pulse = pulse_q;
  assign aliens_left = left_q;
  assign level_clear = clear_q;

endmodule

// File: tb/tb_alien_spawn_ctrl.sv
// Testbench for alien_spawn_ctrl: directed scenarios with literal expectations
// plus randomized play checked every cycle against a behavioural level model.
module tb_alien_spawn_ctrl;

  localparam int N     = 4;
  localparam int DELAY = 120;
  localparam int TOTAL = 8;
  localparam int FRZ   = 90;
  localparam int FPER  = 3;

`ifdef ALIEN_PLAYER_FREEZE_EN
  localparam int RESPAWN_FRAMES = FRZ + DELAY;
`else
  localparam int RESPAWN_FRAMES = DELAY;
`endif

  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         startOfFrame = 1'b0;
  logic         start_level = 1'b0;
  logic [N-1:0] alien_died = '0;
  logic         player_died = 1'b0;
  logic [N-1:0] slot_alive;
  logic [N-1:0] spawn_pulse;
  logic [7:0]   aliens_left;
  logic         level_clear;

  int n_tests = 0;
  int n_fail  = 0;
  int fphase  = 0;
  int sof_seen = 0;
  bit chk_on  = 1'b0;

  alien_spawn_ctrl #(
    .NUM_SLOTS(N), .SPAWN_DELAY_FRAMES(DELAY), .TOTAL_ALIENS(TOTAL), .FREEZE_FRAMES(FRZ)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_level(start_level),
    .alien_died(alien_died), .player_died(player_died), .slot_alive(slot_alive),
    .spawn_pulse(spawn_pulse), .aliens_left(aliens_left), .level_clear(level_clear)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural level model ----------------
  // mode: 0 idle, 1 playing, 2 frozen, 3 level done
  int       m_mode = 0, m_frames = 0, m_spawned = 0, m_left = 0, m_fz = 0;
  int       m_pend = -1;  // slot whose spawn pulse is on the output this cycle
  bit [N-1:0] m_alive = '0;

  task automatic model_step();
    bit [N-1:0] kills, start_alive;
    int np;
    if (start_level) begin
      m_mode = 1; m_frames = 0; m_spawned = 0; m_left = TOTAL; m_fz = 0;
      m_alive = '0; m_pend = -1;
      return;
    end
    if (m_mode == 2) begin
      if (startOfFrame) begin
        m_fz++;
        if (m_fz == FRZ) begin m_mode = 1; m_frames = 0; m_fz = 0; end
      end
      m_pend = -1;
      return;
    end
    if (m_mode != 1) begin
      m_pend = -1;
      return;
    end
    start_alive = m_alive;
    kills = alien_died & start_alive;
    m_left -= $countones(kills);
    m_alive = start_alive & ~kills;
    np = -1;
    if (m_pend >= 0) begin
      if (!player_died) begin m_alive[m_pend] = 1'b1; m_spawned++; end
      m_frames = 0;
    end else begin
      if (startOfFrame && m_frames < DELAY) m_frames++;
      if (m_frames == DELAY && m_spawned < TOTAL && start_alive != {N{1'b1}}) begin
        for (int i = N - 1; i >= 0; i--) if (!start_alive[i]) np = i;
      end
    end
    if (player_died) begin
      m_spawned -= $countones(m_alive);
      m_alive = '0; m_frames = 0; np = -1;
`ifdef ALIEN_PLAYER_FREEZE_EN
      m_mode = 2; m_fz = 0;
`endif
    end
    if (m_left == 0) begin m_mode = 3; np = -1; m_alive = '0; end
    m_pend = np;
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_mode = 0; m_frames = 0; m_spawned = 0; m_left = 0; m_fz = 0;
      m_alive = '0; m_pend = -1;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    bit [N-1:0] e_pulse;
    bit         e_clear;
    if (chk_on) begin
      e_pulse = (m_pend >= 0) ? (N'(1) << m_pend) : '0;
      e_clear = (m_mode == 3);
      n_tests++;
      if (slot_alive !== m_alive || spawn_pulse !== e_pulse ||
          aliens_left !== 8'(m_left) || level_clear !== e_clear) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t alive=%b want %b pulse=%b want %b left=%0d want %0d clear=%b want %b",
                 $time, slot_alive, m_alive, spawn_pulse, e_pulse, aliens_left, m_left,
                 level_clear, e_clear);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called at a falling edge), return after the
  // next falling edge so the registered outputs reflect them.
  task automatic step(input bit s_l, input bit [N-1:0] a_d, input bit p_d);
    startOfFrame = (fphase == 0);
    if (fphase == 0) sof_seen++;
    fphase = (fphase + 1) % FPER;
    start_level = s_l;
    alien_died  = a_d;
    player_died = p_d;
    @(negedge clk);
  endtask

  task automatic wait_pulse(input string name);
    int k;
    for (k = 0; k < 2000; k++) begin
      step(1'b0, '0, 1'b0);
      if (spawn_pulse != '0) break;
    end
    if (k == 2000) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no spawn_pulse within 2000 cycles, expected one", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit [N-1:0] mask;
    int pulses;

    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("reset_alive", slot_alive, 0);
    check("reset_pulse", spawn_pulse, 0);
    check("reset_left", aliens_left, 0);
    check("reset_clear", level_clear, 0);
    resetN = 1'b1;
    step(1'b0, '0, 1'b0);
    check("idle_left", aliens_left, 0);

    // First spawn after start_level
    step(1'b1, '0, 1'b0);
    sof_seen = 0;
    check("start_left", aliens_left, TOTAL);
    wait_pulse("first_spawn");
    check("first_spawn_frames", sof_seen, DELAY);
    check("first_spawn_pulse", spawn_pulse, 4'b0001);
    step(1'b0, '0, 1'b0);
    check("first_spawn_alive", slot_alive, 4'b0001);
    check("first_spawn_pulse_off", spawn_pulse, 0);

    // Fill the remaining slots in index order
    for (int k = 1; k < N; k++) begin
      wait_pulse("fill_spawn");
      check("fill_spawn_pulse", spawn_pulse, 1 << k);
      step(1'b0, '0, 1'b0);
    end
    check("all_alive", slot_alive, 4'b1111);

    // Delay expires with every slot busy, then slot 2 is freed
    pulses = 0;
    repeat (400) begin
      step(1'b0, '0, 1'b0);
      if (spawn_pulse != '0) pulses++;
    end
    check("full_no_spawn", pulses, 0);
    step(1'b0, 4'b0100, 1'b0);
    check("kill2_alive", slot_alive, 4'b1011);
    check("kill2_left", aliens_left, 7);
    step(1'b0, '0, 1'b0);
    check("respawn2_pulse", spawn_pulse, 4'b0100);
    step(1'b0, '0, 1'b0);
    check("respawn2_alive", slot_alive, 4'b1111);

    // Player death together with a kill on slot 0 while two slots are live
    step(1'b1, '0, 1'b0);
    wait_pulse("pd_setup0");
    step(1'b0, '0, 1'b0);
    wait_pulse("pd_setup1");
    step(1'b0, '0, 1'b0);
    check("pd_setup_alive", slot_alive, 4'b0011);
    step(1'b0, 4'b0001, 1'b1);
    sof_seen = 0;
    check("pd_left", aliens_left, 7);
    check("pd_alive", slot_alive, 0);
    wait_pulse("pd_respawn");
    check("pd_respawn_frames", sof_seen, RESPAWN_FRAMES);
    check("pd_respawn_pulse", spawn_pulse, 4'b0001);

    // Full level: every spawned alien is killed
    step(1'b1, '0, 1'b0);
    for (int k = 0; k < TOTAL; k++) begin
      wait_pulse("level_spawn");
      mask = spawn_pulse;
      step(1'b0, '0, 1'b0);
      step(1'b0, mask, 1'b0);
      check("level_left", aliens_left, TOTAL - 1 - k);
    end
    check("level_clear", level_clear, 1);
    pulses = 0;
    repeat (400) begin
      step(1'b0, '0, 1'b0);
      if (spawn_pulse != '0) pulses++;
    end
    check("done_no_spawn", pulses, 0);
    check("done_clear_held", level_clear, 1);

    // Asynchronous reset during the spawn cycle
    step(1'b1, '0, 1'b0);
    wait_pulse("rst_spawn");
    #2 resetN = 1'b0;
    #1;
    check("rst_pulse", spawn_pulse, 0);
    check("rst_alive", slot_alive, 0);
    check("rst_left", aliens_left, 0);
    check("rst_clear", level_clear, 0);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    repeat (5) step(1'b0, '0, 1'b0);
    check("rst_idle_left", aliens_left, 0);
    check("rst_idle_alive", slot_alive, 0);

    // Randomized play
    step(1'b1, '0, 1'b0);
    repeat (8000) begin
      step($urandom_range(0, 2999) == 0,
           ($urandom_range(0, 29) == 0) ? N'($urandom) : '0,
           $urandom_range(0, 399) == 0);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alien_spawn_ctrl.md
ALIEN_SPAWN_CTRL -- requirements
Module: alien_spawn_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of alien instances (slots) sequenced by this block.
REQ-002 Parameter SPAWN_DELAY_FRAMES, default 120, frames between successive spawns.
REQ-003 Parameter TOTAL_ALIENS, default 8, aliens spawned per level.
REQ-004 Parameter FREEZE_FRAMES, default 90, post-player-death freeze length; used only with ALIEN_PLAYER_FREEZE_EN.
REQ-005 clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame.
REQ-008 start_level  in  1  one-cycle pulse that begins a level.
REQ-009 alien_died  in  NUM_SLOTS  per-slot one-cycle death pulse.
REQ-010 player_died  in  1  one-cycle player death pulse.
REQ-011 slot_alive  out  NUM_SLOTS  per-slot alive flag; gates each alien's drawing request.
REQ-012 spawn_pulse  out  NUM_SLOTS  one-cycle pulse that restarts a slot's mover at its initial position.
REQ-013 aliens_left  out  8  TOTAL_ALIENS minus aliens killed this level.
REQ-014 level_clear  out  1  level-complete flag.

Function
REQ-015 States SHALL be IDLE, WAIT, SPAWN, FREEZE, DONE.
REQ-016 IDLE: all outputs inactive; start_level -> WAIT, frame counter = 0, spawned = 0, aliens_left = TOTAL_ALIENS.
REQ-017 WAIT: frame counter SHALL increment on each startOfFrame; on the startOfFrame that makes it SPAWN_DELAY_FRAMES, with spawned < TOTAL_ALIENS and at least one free slot, -> SPAWN.
REQ-018 WAIT with all slots alive at the delay boundary: counter SHALL saturate at SPAWN_DELAY_FRAMES; spawn occurs in the first cycle a slot is free.
REQ-019 SPAWN (exactly one cycle): lowest-index slot free at cycle start gets spawn_pulse=1 and slot_alive set the next cycle; spawned += 1; counter = 0; -> WAIT.
REQ-020 A slot freed by alien_died in the same cycle SHALL NOT be selected until the following cycle.
REQ-021 alien_died on a live slot SHALL clear slot_alive next cycle and decrement aliens_left; on a dead slot SHALL be ignored.
REQ-022 Multiple simultaneous alien_died bits SHALL each decrement aliens_left (popcount of live-slot hits).
REQ-023 aliens_left == 0 -> DONE; level_clear = 1 while in DONE; start_level in DONE -> WAIT with full re-initialisation.
REQ-024 player_died in WAIT or SPAWN SHALL clear all slot_alive, suppress any pending spawn_pulse, subtract the live-slot count from spawned (aliens_left unchanged), reset counter.
REQ-025 player_died and alien_died in the same cycle: alien_died counted first, then REQ-024 applied.
REQ-026 start_level in WAIT/SPAWN/FREEZE SHALL restart the level exactly as from IDLE.
REQ-027 Counters SHALL be sized by $clog2 of their limits and never wrap.

Reset
REQ-028 resetN low SHALL asynchronously force IDLE, slot_alive=0, spawn_pulse=0, aliens_left=0, level_clear=0, all counters 0.
REQ-029 Reset mid-SPAWN SHALL suppress the spawn_pulse; no partial state survives.

Configuration
REQ-030 Macro ALIEN_PLAYER_FREEZE_EN defined: after REQ-024, -> FREEZE; count FREEZE_FRAMES startOfFrame pulses, then -> WAIT with counter 0; spawns inhibited in FREEZE.
REQ-031 Macro undefined: after REQ-024, -> WAIT directly; no FREEZE state logic present; FREEZE_FRAMES unused.

Verification
REQ-032 Reset, start_level, 120 frames -> spawn_pulse=0001 one cycle, slot_alive=0001.
REQ-033 Slots 0-3 alive, 120 frames elapse, alien_died=0100 -> next cycle slot 2 free, following cycle spawn_pulse=0100.
REQ-034 Eight spawns with each alien killed -> aliens_left 8->0, level_clear=1, no further spawns.
REQ-035 Two live slots, player_died with alien_died on slot 0 -> aliens_left -1, slot_alive=0000, spawned reduced by 1.
REQ-036 With ALIEN_PLAYER_FREEZE_EN: player_died -> no spawn_pulse for 90+120 frames, then spawn; without: first spawn after 120 frames.
REQ-037 resetN asserted during SPAWN cycle -> spawn_pulse=0 same cycle, all outputs 0, state IDLE.
